// File: rtl/secure_regfile_pkg.sv
// rtl/secure_regfile_pkg.sv - shared types, constants and grant decision for secure_regfile
package secure_regfile_pkg;

    typedef enum logic [1:0] {
        OP_READ      = 2'd0,
        OP_WRITE     = 2'd1,
        OP_LOCK      = 2'd2,
        OP_SET_OWNER = 2'd3
    } op_e;

    typedef enum logic {
        LS_UNLOCKED = 1'b0,
        LS_LOCKED   = 1'b1
    } lock_state_e;

    localparam int PRIV_TID = 0;

    // Ownership changes are reserved for the privileged thread; locks freeze data and owner.
    function automatic logic grant_ok(
        input op_e  op,
        input logic privileged,
        input logic owner_match,
        input logic locked,
        input logic addr_ok
    );
        logic g;
        case (op)
            OP_READ, OP_LOCK: g = privileged | owner_match;
            OP_WRITE:         g = (privileged | owner_match) & ~locked;
            OP_SET_OWNER:     g = privileged & ~locked;
            default:          g = 1'b0;
        endcase
        return addr_ok & g;
    endfunction

endpackage

// File: rtl/secure_reg_slot.sv
// rtl/secure_reg_slot.sv - one register entry: data, owner thread id and sticky lock FSM
module secure_reg_slot
    import secure_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TID_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  lock_en,
    input  logic                  own_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [TID_WIDTH-1:0]  owner_in,
    output logic [DATA_WIDTH-1:0] data,
    output logic [TID_WIDTH-1:0]  owner,
    output logic                  locked
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TID_WIDTH-1:0]  owner_q, owner_d;
    lock_state_e           state_q, state_d;

    always_comb begin
        data_d  = data_q;
        owner_d = owner_q;
        state_d = state_q;
        if (wr_en) begin
            data_d = data_in;
        end
        if (own_en) begin
            owner_d = owner_in;
        end
        case (state_q)
            LS_UNLOCKED: if (lock_en) state_d = LS_LOCKED;
            LS_LOCKED:   state_d = LS_LOCKED;
            default:     state_d = LS_LOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            owner_q <= '0;
            state_q <= LS_UNLOCKED;
        end else begin
            data_q  <= data_d;
            owner_q <= owner_d;
            state_q <= state_d;
        end
    end

    assign data   = data_q;
    assign owner  = owner_q;
    assign locked = (state_q == LS_LOCKED);

endmodule

// File: rtl/secure_regfile.sv
// rtl/secure_regfile.sv - thread-tagged register file with per-entry owners, locks and violation count
module secure_regfile
    import secure_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int TID_WIDTH  = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  access_en,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [TID_WIDTH-1:0]  thread_id,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  viol_count,
    output logic [NUM_REGS-1:0]   lock_status
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] slot_data  [NUM_REGS];
    logic [TID_WIDTH-1:0]  slot_owner [NUM_REGS];
    logic [NUM_REGS-1:0]   slot_locked;

    logic [NUM_REGS-1:0]   sel, wr_en, lock_en, own_en;
    logic                  addr_ok, privileged, owner_match, grant;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [TID_WIDTH-1:0]  sel_owner;
    logic                  sel_locked;
    op_e                   op_cmd;

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  viol_count_q, viol_count_d;

    // One-hot decode doubles as the range check: an out-of-range address selects nothing.
    always_comb begin
        sel        = '0;
        sel_data   = '0;
        sel_owner  = '0;
        sel_locked = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = (addr == ADDR_WIDTH'(i));
            if (sel[i]) begin
                sel_data   = slot_data[i];
                sel_owner  = slot_owner[i];
                sel_locked = slot_locked[i];
            end
        end
        addr_ok = |sel;
    end

    always_comb begin
        op_cmd      = op_e'(op);
        privileged  = (thread_id == TID_WIDTH'(PRIV_TID));
        owner_match = (thread_id == sel_owner);
        grant       = grant_ok(op_cmd, privileged, owner_match, sel_locked, addr_ok);
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_en[i]   = access_en & grant & sel[i] & (op_cmd == OP_WRITE);
            lock_en[i] = access_en & grant & sel[i] & (op_cmd == OP_LOCK);
            own_en[i]  = access_en & grant & sel[i] & (op_cmd == OP_SET_OWNER);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : gen_slot
            secure_reg_slot #(
                .DATA_WIDTH (DATA_WIDTH),
                .TID_WIDTH  (TID_WIDTH)
            ) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en    (wr_en[g]),
                .lock_en  (lock_en[g]),
                .own_en   (own_en[g]),
                .data_in  (data_in),
                .owner_in (data_in[TID_WIDTH-1:0]),
                .data     (slot_data[g]),
                .owner    (slot_owner[g]),
                .locked   (slot_locked[g])
            );
        end
    endgenerate

    always_comb begin
        rd_valid_d   = access_en & grant & (op_cmd == OP_READ);
        data_out_d   = rd_valid_d ? sel_data : '0;
        err_d        = access_en & ~grant;
        viol_count_d = viol_count_q;
        if (err_d && viol_count_q != CNT_MAX) begin
            viol_count_d = viol_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q   <= '0;
            rd_valid_q   <= 1'b0;
            err_q        <= 1'b0;
            viol_count_q <= '0;
        end else begin
            data_out_q   <= data_out_d;
            rd_valid_q   <= rd_valid_d;
            err_q        <= err_d;
            viol_count_q <= viol_count_d;
        end
    end

    assign data_out    = data_out_q;
    assign rd_valid    = rd_valid_q;
    assign err         = err_q;
    assign viol_count  = viol_count_q;
    assign lock_status = slot_locked;

endmodule

// File: tb/tb_secure_regfile.sv
// tb/tb_secure_regfile.sv - directed self-checking bench for secure_regfile
module tb_secure_regfile;

    localparam logic [1:0] RD = 2'd0, WR = 2'd1, LK = 2'd2, SO = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        en_a = 1'b0;
    logic [1:0]  op_a = '0;
    logic [2:0]  addr_a = '0;
    logic [3:0]  tid_a = '0;
    logic [31:0] din_a = '0;
    logic [31:0] dout_a;
    logic        rdv_a, err_a;
    logic [7:0]  vc_a;
    logic [7:0]  ls_a;

    // Instance B: 6 entries, 2-bit violation counter
    logic        en_b = 1'b0;
    logic [1:0]  op_b = '0;
    logic [2:0]  addr_b = '0;
    logic [3:0]  tid_b = '0;
    logic [31:0] din_b = '0;
    logic [31:0] dout_b;
    logic        rdv_b, err_b;
    logic [1:0]  vc_b;
    logic [5:0]  ls_b;

    int checks = 0;
    int failures = 0;

    secure_regfile dut_a (
        .clk(clk), .rst_n(rst_n), .access_en(en_a), .op(op_a), .addr(addr_a),
        .thread_id(tid_a), .data_in(din_a), .data_out(dout_a), .rd_valid(rdv_a),
        .err(err_a), .viol_count(vc_a), .lock_status(ls_a)
    );

    secure_regfile #(.NUM_REGS(6), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .access_en(en_b), .op(op_b), .addr(addr_b),
        .thread_id(tid_b), .data_in(din_b), .data_out(dout_b), .rd_valid(rdv_b),
        .err(err_b), .viol_count(vc_b), .lock_status(ls_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd_a(input logic [1:0] o, input logic [2:0] a, input logic [3:0] t, input logic [31:0] d);
        op_a = o; addr_a = a; tid_a = t; din_a = d; en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
    endtask

    task automatic cmd_b(input logic [1:0] o, input logic [2:0] a, input logic [3:0] t, input logic [31:0] d);
        op_b = o; addr_b = a; tid_b = t; din_b = d; en_b = 1'b1;
        @(posedge clk); #1;
        en_b = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 64'(dout_a), 64'd0);
        chk("rst_rdv", 64'(rdv_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        chk("rst_vc", 64'(vc_a), 64'd0);
        chk("rst_ls", 64'(ls_a), 64'd0);
        rst_n = 1'b1;

        cmd_a(WR, 3'd2, 4'd0, 32'hDEADBEEF);
        chk("wr0_err", 64'(err_a), 64'd0);
        chk("wr0_rdv", 64'(rdv_a), 64'd0);
        cmd_a(RD, 3'd2, 4'd0, 32'h0);
        chk("rd0_rdv", 64'(rdv_a), 64'd1);
        chk("rd0_data", 64'(dout_a), 64'hDEADBEEF);
        chk("rd0_err", 64'(err_a), 64'd0);
        idle();
        chk("idle_rdv", 64'(rdv_a), 64'd0);
        chk("idle_dout", 64'(dout_a), 64'd0);

        cmd_a(RD, 3'd2, 4'd5, 32'h0);
        chk("rd5_err", 64'(err_a), 64'd1);
        chk("rd5_rdv", 64'(rdv_a), 64'd0);
        chk("rd5_dout", 64'(dout_a), 64'd0);
        chk("rd5_vc", 64'(vc_a), 64'd1);
        idle();
        chk("err_pulse", 64'(err_a), 64'd0);

        cmd_a(SO, 3'd2, 4'd0, 32'h5);
        chk("so_err", 64'(err_a), 64'd0);
        cmd_a(WR, 3'd2, 4'd5, 32'h1234);
        chk("wr5_err", 64'(err_a), 64'd0);
        cmd_a(RD, 3'd2, 4'd5, 32'h0);
        chk("rd5b_rdv", 64'(rdv_a), 64'd1);
        chk("rd5b_data", 64'(dout_a), 64'h1234);
        chk("rd5b_vc", 64'(vc_a), 64'd1);

        cmd_a(LK, 3'd2, 4'd5, 32'h0);
        chk("lk_err", 64'(err_a), 64'd0);
        chk("lk_ls", 64'(ls_a), 64'h04);
        cmd_a(WR, 3'd2, 4'd0, 32'hFFFF);
        chk("wr_locked_err", 64'(err_a), 64'd1);
        cmd_a(SO, 3'd2, 4'd0, 32'h3);
        chk("so_locked_err", 64'(err_a), 64'd1);
        chk("locked_vc", 64'(vc_a), 64'd3);
        cmd_a(RD, 3'd2, 4'd5, 32'h0);
        chk("locked_data", 64'(dout_a), 64'h1234);
        chk("locked_owner_kept", 64'(err_a), 64'd0);
        cmd_a(LK, 3'd2, 4'd5, 32'h0);
        chk("relock_err", 64'(err_a), 64'd0);
        chk("relock_ls", 64'(ls_a), 64'h04);
        cmd_a(LK, 3'd4, 4'd3, 32'h0);
        chk("lk_nonowner_err", 64'(err_a), 64'd1);
        chk("lk_nonowner_vc", 64'(vc_a), 64'd4);
        chk("lk_nonowner_ls", 64'(ls_a), 64'h04);

        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        chk("rst2_ls", 64'(ls_a), 64'd0);
        chk("rst2_vc", 64'(vc_a), 64'd0);
        cmd_a(RD, 3'd2, 4'd0, 32'h0);
        chk("rst2_data", 64'(dout_a), 64'd0);
        chk("rst2_rdv", 64'(rdv_a), 64'd1);
        cmd_a(WR, 3'd2, 4'd0, 32'h9);
        chk("rst2_unlocked", 64'(err_a), 64'd0);

        cmd_a(WR, 3'd1, 4'd0, 32'hA5A5);
        cmd_a(RD, 3'd1, 4'd0, 32'h0);
        chk("rdrst_pre", 64'(dout_a), 64'hA5A5);
        cmd_a(RD, 3'd1, 4'd0, 32'h0);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        chk("rdrst_rdv", 64'(rdv_a), 64'd0);
        chk("rdrst_dout", 64'(dout_a), 64'd0);

        cmd_a(WR, 3'd7, 4'd0, 32'h77);
        cmd_a(RD, 3'd7, 4'd0, 32'h0);
        chk("b2b_data", 64'(dout_a), 64'h77);
        chk("b2b_rdv", 64'(rdv_a), 64'd1);

        cmd_b(RD, 3'd7, 4'd0, 32'h0);
        chk("oob_rd_err", 64'(err_b), 64'd1);
        chk("oob_rd_rdv", 64'(rdv_b), 64'd0);
        chk("sat_vc1", 64'(vc_b), 64'd1);
        cmd_b(WR, 3'd6, 4'd0, 32'h66);
        chk("sat_vc2", 64'(vc_b), 64'd2);
        cmd_b(LK, 3'd7, 4'd0, 32'h0);
        chk("sat_vc3", 64'(vc_b), 64'd3);
        chk("oob_lk_ls", 64'(ls_b), 64'd0);
        cmd_b(SO, 3'd6, 4'd0, 32'h1);
        chk("sat_vc4", 64'(vc_b), 64'd3);
        chk("sat_err4", 64'(err_b), 64'd1);
        cmd_b(RD, 3'd6, 4'd0, 32'h0);
        chk("sat_vc5", 64'(vc_b), 64'd3);
        cmd_b(WR, 3'd5, 4'd0, 32'h55);
        chk("b_wr5_err", 64'(err_b), 64'd0);
        cmd_b(RD, 3'd5, 4'd0, 32'h0);
        chk("b_rd5_data", 64'(dout_b), 64'h55);
        chk("b_rd5_vc", 64'(vc_b), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
